cpu_step_sequencer: RTL and testbench



---
 rtl/cpu_step_sequencer_pkg.sv | 20 ++
 rtl/cpu_step_sequencer_bus_timeout_counter.sv | 30 +++
 rtl/cpu_step_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cpu_step_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_sequencer_pkg.sv
// Shared types and constants for the micro-step sequencer and its helpers.
`timescale 1ns/1ps

package cpu_step_sequencer_pkg;

    localparam int unsigned STEP_W = 3;
    localparam logic [STEP_W-1:0] STEP_LAST = 3'd7;

    typedef enum logic [1:0] {
        StRun,
        StWaitMem,
        StHalt,
        StFault
    } seq_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_STEP_OVR = 2'b01;
    localparam logic [1:0] FAULT_BUS_TO   = 2'b10;

endpackage

// File: rtl/cpu_step_sequencer_bus_timeout_counter.sv
// Wait-cycle counter for a bus handshake; flags the cycle in which the limit is reached.
`timescale 1ns/1ps

module bus_timeout_counter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    // High during the TIMEOUT-th enabled cycle, i.e. the count would reach TIMEOUT now.
    assign expired = en && (count_q == TO_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_step_sequencer.sv
// Micro-step sequencer: advances the decoder step per commit, owns the memory handshake,
// debug halt/single-step at instruction boundaries and sticky fault detection.
`timescale 1ns/1ps

module cpu_step_sequencer
    import cpu_step_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned TO_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [STEP_W-1:0]     dec_step_o,
    input  logic                  dec_reset_state_i,
    input  logic                  dec_mem_rd_i,
    input  logic                  dec_mem_wr_i,
    output logic                  commit_o,
    output logic                  instr_done_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    input  logic                  bus_ready_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    input  logic                  halt_i,
    input  logic                  step_i,
    output logic                  halted_o,
    output logic                  fault_o,
    output logic [1:0]            fault_code_o
);

    seq_state_e             state_q, state_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [DATA_WIDTH-1:0]  mem_rdata_q, mem_rdata_d;
    logic [1:0]             fault_code_q, fault_code_d;
    logic                   instr_done_q, instr_done_d;
    logic                   bypass_q, bypass_d;
    logic                   wait_we_q, wait_we_d;

    logic mem;
    logic commit, req, we, halted;
    logic to_en, to_clr, to_expired;

    assign mem = dec_mem_rd_i | dec_mem_wr_i;

    bus_timeout_counter #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        mem_rdata_d  = mem_rdata_q;
        fault_code_d = fault_code_q;
        instr_done_d = 1'b0;
        bypass_d     = bypass_q;
        wait_we_d    = wait_we_q;
        commit       = 1'b0;
        req          = 1'b0;
        we           = 1'b0;
        halted       = 1'b0;
        to_en        = 1'b0;
        to_clr       = 1'b0;

        unique case (state_q)
            StRun: begin
                if (step_q == '0 && halt_i && !bypass_q) begin
                    state_d = StHalt;
                end else if (mem) begin
                    req = 1'b1;
                    we  = dec_mem_wr_i;
                    if (bus_ready_i) begin
                        commit = 1'b1;
                    end else begin
                        state_d   = StWaitMem;
                        wait_we_d = dec_mem_wr_i;
                        to_clr    = 1'b1;
                    end
                end else begin
                    commit = 1'b1;
                end
            end
            StWaitMem: begin
                // Decoder mem flags are ignored here; the latched direction keeps the bus stable.
                req   = 1'b1;
                we    = wait_we_q;
                to_en = 1'b1;
                if (bus_ready_i) begin
                    commit  = 1'b1;
                    state_d = StRun;
                    to_clr  = 1'b1;
                end else if (to_expired) begin
                    state_d      = StFault;
                    fault_code_d = FAULT_BUS_TO;
                end
            end
            StHalt: begin
                halted = 1'b1;
                if (!halt_i) begin
                    state_d = StRun;
                end else if (step_i) begin
                    state_d  = StRun;
                    bypass_d = 1'b1;
                end
            end
            StFault: begin
            end
            default: begin
                state_d = StFault;
            end
        endcase

        if (commit) begin
            if (req && !we) begin
                mem_rdata_d = bus_rdata_i;
            end
            if (step_q == '0) begin
                bypass_d = 1'b0;
            end
            if (dec_reset_state_i) begin
                step_d       = '0;
                instr_done_d = 1'b1;
            end else if (step_q == STEP_LAST) begin
                state_d      = StFault;
                fault_code_d = FAULT_STEP_OVR;
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            step_q       <= '0;
            mem_rdata_q  <= '0;
            fault_code_q <= FAULT_NONE;
            instr_done_q <= 1'b0;
            bypass_q     <= 1'b0;
            wait_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            mem_rdata_q  <= mem_rdata_d;
            fault_code_q <= fault_code_d;
            instr_done_q <= instr_done_d;
            bypass_q     <= bypass_d;
            wait_we_q    <= wait_we_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted, even mid-transaction.
    assign commit_o     = commit & rst_n;
    assign bus_req_o    = req & rst_n;
    assign bus_we_o     = we & rst_n;
    assign halted_o     = halted & rst_n;
    assign dec_step_o   = step_q;
    assign instr_done_o = instr_done_q;
    assign mem_rdata_o  = mem_rdata_q;
    assign fault_o      = (state_q == StFault);
    assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Scoreboard bench: each driven cycle pushes its expected outputs, checked mid-cycle.
`timescale 1ns/1ps

module tb_cpu_step_sequencer;

    typedef struct packed {
        logic [2:0] step;
        logic       commit;
        logic       req;
        logic       we;
        logic       halted;
        logic       done;
        logic       fault;
        logic [1:0] code;
        logic [7:0] rdata;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] dec_step;
    logic       dec_reset_state, dec_mem_rd, dec_mem_wr;
    logic       commit, instr_done, bus_req, bus_we, bus_ready;
    logic [7:0] bus_rdata, mem_rdata;
    logic       halt, step, halted, fault;
    logic [1:0] fault_code;

    int n_checks = 0;
    int n_errors = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    cpu_step_sequencer #(
        .DATA_WIDTH (8),
        .TIMEOUT    (4),
        .TO_WIDTH   (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dec_step_o        (dec_step),
        .dec_reset_state_i (dec_reset_state),
        .dec_mem_rd_i      (dec_mem_rd),
        .dec_mem_wr_i      (dec_mem_wr),
        .commit_o          (commit),
        .instr_done_o      (instr_done),
        .bus_req_o         (bus_req),
        .bus_we_o          (bus_we),
        .bus_ready_i       (bus_ready),
        .bus_rdata_i       (bus_rdata),
        .mem_rdata_o       (mem_rdata),
        .halt_i            (halt),
        .step_i            (step),
        .halted_o          (halted),
        .fault_o           (fault),
        .fault_code_o      (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t obs();
        return {dec_step, commit, bus_req, bus_we, halted, instr_done, fault, fault_code,
                mem_rdata};
    endfunction

    // flags = {commit, req, we, halted, done, fault}
    function automatic exp_t mk(input logic [2:0] s, input logic [5:0] flags,
                                input logic [1:0] code, input logic [7:0] rd);
        return {s, flags, code, rd};
    endfunction

    // dec = {rd, wr, reset_state, ready}, dbg = {halt, step}; called at a falling edge.
    task automatic cyc(input string tag, input logic [3:0] dec, input logic [7:0] rdat,
                       input logic [1:0] dbg, input exp_t e);
        {dec_mem_rd, dec_mem_wr, dec_reset_state, bus_ready} = dec;
        bus_rdata = rdat;
        {halt, step} = dbg;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {dec_mem_rd, dec_mem_wr, dec_reset_state, bus_ready} = 4'b0000;
        bus_rdata = 8'h00;
        {halt, step} = 2'b00;
        #1;
        check_eq("reset outputs", 32'(obs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        #2;
        if (exp_q.size() != 0) begin
            check_eq(tag_q.pop_front(), 32'(obs()), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Zero-wait ADDI-like sequence
        cyc("addi s0",  4'b1001, 8'h11, 2'b00, mk(3'd0, 6'b110000, 2'b00, 8'h00));
        cyc("addi s1",  4'b1001, 8'h22, 2'b00, mk(3'd1, 6'b110000, 2'b00, 8'h11));
        cyc("addi s2",  4'b0010, 8'h00, 2'b00, mk(3'd2, 6'b100000, 2'b00, 8'h22));
        cyc("addi nxt", 4'b1001, 8'h33, 2'b00, mk(3'd0, 6'b110010, 2'b00, 8'h22));

        // LD with 3-cycle latency at step 2
        do_reset();
        cyc("ld s0",   4'b0000, 8'h00, 2'b00, mk(3'd0, 6'b100000, 2'b00, 8'h00));
        cyc("ld s1",   4'b0000, 8'h00, 2'b00, mk(3'd1, 6'b100000, 2'b00, 8'h00));
        cyc("ld req",  4'b1000, 8'hFF, 2'b00, mk(3'd2, 6'b010000, 2'b00, 8'h00));
        cyc("ld wait", 4'b1000, 8'hFF, 2'b00, mk(3'd2, 6'b010000, 2'b00, 8'h00));
        cyc("ld rdy",  4'b1001, 8'hA5, 2'b00, mk(3'd2, 6'b110000, 2'b00, 8'h00));
        cyc("ld s3",   4'b0010, 8'h00, 2'b00, mk(3'd3, 6'b100000, 2'b00, 8'hA5));
        cyc("ld nxt",  4'b0000, 8'h00, 2'b00, mk(3'd0, 6'b100010, 2'b00, 8'hA5));

        // Read+write together: write wins, latched direction held, data register untouched
        do_reset();
        cyc("rw req", 4'b1100, 8'h3C, 2'b00, mk(3'd0, 6'b011000, 2'b00, 8'h00));
        cyc("rw rdy", 4'b1001, 8'h3C, 2'b00, mk(3'd0, 6'b111000, 2'b00, 8'h00));
        cyc("rw s1",  4'b0010, 8'h3C, 2'b00, mk(3'd1, 6'b100000, 2'b00, 8'h00));
        cyc("rw nxt", 4'b0000, 8'h00, 2'b00, mk(3'd0, 6'b100010, 2'b00, 8'h00));

        // Halt mid-instruction, then single-step exactly one instruction
        do_reset();
        cyc("h s0",      4'b0000, 8'h00, 2'b00, mk(3'd0, 6'b100000, 2'b00, 8'h00));
        cyc("h s1",      4'b0000, 8'h00, 2'b00, mk(3'd1, 6'b100000, 2'b00, 8'h00));
        cyc("h s2",      4'b0000, 8'h00, 2'b00, mk(3'd2, 6'b100000, 2'b00, 8'h00));
        cyc("h s3",      4'b0000, 8'h00, 2'b10, mk(3'd3, 6'b100000, 2'b00, 8'h00));
        cyc("h s4",      4'b0010, 8'h00, 2'b10, mk(3'd4, 6'b100000, 2'b00, 8'h00));
        cyc("h bnd",     4'b1001, 8'h77, 2'b10, mk(3'd0, 6'b000010, 2'b00, 8'h00));
        cyc("h hold",    4'b1001, 8'h77, 2'b10, mk(3'd0, 6'b000100, 2'b00, 8'h00));
        cyc("h step",    4'b1001, 8'h77, 2'b11, mk(3'd0, 6'b000100, 2'b00, 8'h00));
        cyc("h run0",    4'b1001, 8'h77, 2'b10, mk(3'd0, 6'b110000, 2'b00, 8'h00));
        cyc("h run1",    4'b0010, 8'h00, 2'b11, mk(3'd1, 6'b100000, 2'b00, 8'h77));
        cyc("h rehalt",  4'b1001, 8'h77, 2'b10, mk(3'd0, 6'b000010, 2'b00, 8'h77));
        cyc("h halted",  4'b0000, 8'h00, 2'b10, mk(3'd0, 6'b000100, 2'b00, 8'h77));
        cyc("h release", 4'b0000, 8'h00, 2'b00, mk(3'd0, 6'b000100, 2'b00, 8'h77));
        cyc("h resume",  4'b0000, 8'h00, 2'b00, mk(3'd0, 6'b100000, 2'b00, 8'h77));

        // Bus timeout with TIMEOUT=4
        do_reset();
        cyc("to req", 4'b1000, 8'h99, 2'b00, mk(3'd0, 6'b010000, 2'b00, 8'h00));
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("to wait%0d", i), 4'b1000, 8'h99, 2'b00,
                mk(3'd0, 6'b010000, 2'b00, 8'h00));
        end
        cyc("to fault",    4'b1001, 8'h99, 2'b00, mk(3'd0, 6'b000001, 2'b10, 8'h00));
        cyc("to late rdy", 4'b1001, 8'h99, 2'b00, mk(3'd0, 6'b000001, 2'b10, 8'h00));

        // Step overrun: reset_state never asserted
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("ovr s%0d", i), 4'b0000, 8'h00, 2'b00,
                mk(3'(i), 6'b100000, 2'b00, 8'h00));
        end
        cyc("ovr fault",  4'b0010, 8'h00, 2'b11, mk(3'd7, 6'b000001, 2'b01, 8'h00));
        cyc("ovr sticky", 4'b1001, 8'h55, 2'b00, mk(3'd7, 6'b000001, 2'b01, 8'h00));

        // Asynchronous reset in the middle of a wait state
        do_reset();
        cyc("rst s0",   4'b0000, 8'h00, 2'b00, mk(3'd0, 6'b100000, 2'b00, 8'h00));
        cyc("rst req",  4'b1000, 8'h00, 2'b00, mk(3'd1, 6'b010000, 2'b00, 8'h00));
        cyc("rst wait", 4'b1000, 8'h00, 2'b00, mk(3'd1, 6'b010000, 2'b00, 8'h00));
        do_reset();
        cyc("rst after", 4'b0010, 8'h00, 2'b00, mk(3'd0, 6'b100000, 2'b00, 8'h00));

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
